// File: rtl/video_fetch_arbiter.sv
// Shares the byte-wide video memory port between the Apple II video fetcher and the VGC.
// Each request becomes four pipelined byte reads, packed little-endian into a 32-bit word.
module video_fetch_arbiter #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter logic [5:0]  BANK_HI     = 6'h00,
   parameter logic [15:0] VGC_OFFSET  = 16'h2000
) (
   input  logic        clk_vid,
   input  logic        reset,
   input  logic        apple_video_rd,
   input  logic [15:0] apple_video_addr,
   input  logic        apple_video_bank,
   output logic [31:0] apple_video_data,
   output logic        apple_video_valid,
   output logic        apple_video_busy,
   input  logic        vgc_rd,
   input  logic [12:0] vgc_address,
   output logic [31:0] vgc_data,
   output logic        vgc_valid,
   output logic        vgc_busy,
   output logic [22:0] video_addr,
   output logic        video_rd,
   input  logic [7:0]  video_data
);

   typedef enum logic {S_IDLE, S_ISSUE} state_e;
   typedef enum logic {OWN_APPLE, OWN_VGC} owner_e;

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   owner_e      last_q, last_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [16:0] base_q, base_d;
   logic        video_rd_q, video_rd_d;
   logic [22:0] video_addr_q, video_addr_d;

   logic        apple_pend_q, apple_fly_q;
   logic [16:0] apple_slot_q;
   logic        vgc_pend_q, vgc_fly_q;
   logic [15:0] vgc_slot_q;

   logic        apple_acc, vgc_acc;
   logic        apple_eff, vgc_eff;
   logic [16:0] apple_eff_base;
   logic [15:0] vgc_low_in, vgc_eff_low;
   logic        grant_apple, grant_vgc;

   logic [3:0]  tag_q [MEM_LATENCY];
   logic [3:0]  tag_in, tag_out;
   logic        ret_vld, ret_vgc;
   logic [1:0]  ret_lane;
   logic        apple_done, vgc_done;

   logic [23:0] apple_asm_q, vgc_asm_q;
   logic [31:0] apple_data_q, vgc_data_q;
   logic        apple_valid_q, vgc_valid_q;

   assign apple_video_busy = apple_pend_q | apple_fly_q;
   assign vgc_busy         = vgc_pend_q | vgc_fly_q;
   assign apple_acc        = apple_video_rd & ~apple_video_busy;
   assign vgc_acc          = vgc_rd & ~vgc_busy;

   // A request arriving while the port is free is granted in the same cycle it is accepted.
   assign apple_eff      = apple_pend_q | apple_acc;
   assign vgc_eff        = vgc_pend_q | vgc_acc;
   assign apple_eff_base = apple_pend_q ? apple_slot_q : {apple_video_bank, apple_video_addr};
   assign vgc_low_in     = VGC_OFFSET + {1'b0, vgc_address, 2'b00};
   assign vgc_eff_low    = vgc_pend_q ? vgc_slot_q : vgc_low_in;

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_APPLE;
         last_q       <= OWN_VGC;
         cnt_q        <= '0;
         base_q       <= '0;
         video_rd_q   <= 1'b0;
         video_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         video_rd_q   <= video_rd_d;
         video_addr_q <= video_addr_d;
      end
   end

   always_comb begin
      logic want;
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      grant_apple = 1'b0;
      grant_vgc   = 1'b0;
      want        = 1'b0;
      case (state_q)
         S_IDLE: want = 1'b1;
         S_ISSUE: begin
            if (cnt_q == 2'd3) begin
               want    = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (want && (apple_eff || vgc_eff)) begin
         if (apple_eff && (!vgc_eff || last_q == OWN_VGC)) begin
            grant_apple = 1'b1;
            owner_d     = OWN_APPLE;
            base_d      = apple_eff_base;
         end else begin
            grant_vgc = 1'b1;
            owner_d   = OWN_VGC;
            base_d    = {1'b1, vgc_eff_low};
         end
         last_d  = owner_d;
         state_d = S_ISSUE;
         cnt_d   = 2'd0;
      end
   end

   // Strobe and address are registered from next-state so they line up with state_q/cnt_q.
   always_comb begin
      video_rd_d   = (state_d == S_ISSUE);
      video_addr_d = video_addr_q;
      if (video_rd_d) begin
         video_addr_d = {BANK_HI, base_d[16], base_d[15:0] + {14'd0, cnt_d}};
      end
   end

   assign video_rd   = video_rd_q;
   assign video_addr = video_addr_q;

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         apple_pend_q <= 1'b0;
         apple_slot_q <= '0;
         apple_fly_q  <= 1'b0;
         vgc_pend_q   <= 1'b0;
         vgc_slot_q   <= '0;
         vgc_fly_q    <= 1'b0;
      end else begin
         if (grant_apple) begin
            apple_pend_q <= 1'b0;
         end else if (apple_acc) begin
            apple_pend_q <= 1'b1;
            apple_slot_q <= {apple_video_bank, apple_video_addr};
         end
         if (grant_vgc) begin
            vgc_pend_q <= 1'b0;
         end else if (vgc_acc) begin
            vgc_pend_q <= 1'b1;
            vgc_slot_q <= vgc_low_in;
         end
         if (grant_apple) begin
            apple_fly_q <= 1'b1;
         end else if (apple_done) begin
            apple_fly_q <= 1'b0;
         end
         if (grant_vgc) begin
            vgc_fly_q <= 1'b1;
         end else if (vgc_done) begin
            vgc_fly_q <= 1'b0;
         end
      end
   end

   assign tag_in = {video_rd_q, owner_q == OWN_VGC, cnt_q};

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         tag_q[0] <= tag_in;
         for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign tag_out    = tag_q[MEM_LATENCY-1];
   assign ret_vld    = tag_out[3];
   assign ret_vgc    = tag_out[2];
   assign ret_lane   = tag_out[1:0];
   assign apple_done = ret_vld & ~ret_vgc & (ret_lane == 2'd3);
   assign vgc_done   = ret_vld &  ret_vgc & (ret_lane == 2'd3);

   always_ff @(posedge clk_vid) begin
      if (reset) begin
         apple_asm_q   <= '0;
         vgc_asm_q     <= '0;
         apple_data_q  <= '0;
         vgc_data_q    <= '0;
         apple_valid_q <= 1'b0;
         vgc_valid_q   <= 1'b0;
      end else begin
         apple_valid_q <= apple_done;
         vgc_valid_q   <= vgc_done;
         if (apple_done) apple_data_q <= {video_data, apple_asm_q};
         if (vgc_done)   vgc_data_q   <= {video_data, vgc_asm_q};
         if (ret_vld && ret_lane != 2'd3) begin
            if (ret_vgc) vgc_asm_q[{ret_lane, 3'b000} +: 8]   <= video_data;
            else         apple_asm_q[{ret_lane, 3'b000} +: 8] <= video_data;
         end
      end
   end

   assign apple_video_data  = apple_data_q;
   assign apple_video_valid = apple_valid_q;
   assign vgc_data          = vgc_data_q;
   assign vgc_valid         = vgc_valid_q;

endmodule

// File: tb/tb_video_fetch_arbiter.sv
// Bench for video_fetch_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level schedule model of port grants, strobes and returned words.
module tb_video_fetch_arbiter;

   localparam int L   = 2;
   localparam int INF = 32'h7fffffff;

   logic        clk = 1'b0;
   logic        reset;
   logic        apple_video_rd;
   logic [15:0] apple_video_addr;
   logic        apple_video_bank;
   logic [31:0] apple_video_data;
   logic        apple_video_valid;
   logic        apple_video_busy;
   logic        vgc_rd;
   logic [12:0] vgc_address;
   logic [31:0] vgc_data;
   logic        vgc_valid;
   logic        vgc_busy;
   logic [22:0] video_addr;
   logic        video_rd;
   logic [7:0]  video_data;

   video_fetch_arbiter #(
      .MEM_LATENCY(L),
      .BANK_HI(6'h00),
      .VGC_OFFSET(16'h2000)
   ) dut (
      .clk_vid(clk),
      .reset(reset),
      .apple_video_rd(apple_video_rd),
      .apple_video_addr(apple_video_addr),
      .apple_video_bank(apple_video_bank),
      .apple_video_data(apple_video_data),
      .apple_video_valid(apple_video_valid),
      .apple_video_busy(apple_video_busy),
      .vgc_rd(vgc_rd),
      .vgc_address(vgc_address),
      .vgc_data(vgc_data),
      .vgc_valid(vgc_valid),
      .vgc_busy(vgc_busy),
      .video_addr(video_addr),
      .video_rd(video_rd),
      .video_data(video_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit hash_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [22:0] a);
      logic [7:0] b;
      b = a[7:0];
      if (hash_en) b = b ^ a[15:8] ^ {7'd0, a[16]};
      return b;
   endfunction

   // Memory: the byte for a strobe in cycle S is on video_data during cycle S+L.
   logic [7:0] mem_pipe [L];
   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
      mem_pipe[0] <= video_rd ? mem_byte(video_addr) : 8'hEE;
   end
   assign video_data = mem_pipe[L-1];

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // Schedule model: everything is expressed as absolute cycle numbers.
   logic [22:0] exp_addr [int];
   logic [31:0] exp_aw [int];
   logic [31:0] exp_vw [int];
   bit          pend [2];
   logic [16:0] paddr [2];
   int          done_c [2];
   int          last_g;
   int          port_free;
   bit          checks_on = 1'b0;
   bit          rst_prev = 1'b0;
   logic [31:0] hold_a, hold_v;
   logic [22:0] hold_addr;

   always @(negedge clk) begin
      int c;
      c = cyc;
      if (checks_on) begin
         if (rst_prev) begin
            hold_a = '0;
            hold_v = '0;
            hold_addr = '0;
         end
         if (exp_addr.exists(c)) hold_addr = exp_addr[c];
         chk("video_rd", {31'd0, video_rd}, {31'd0, exp_addr.exists(c)});
         chk("video_addr", {9'd0, video_addr}, {9'd0, hold_addr});
         if (exp_aw.exists(c)) hold_a = exp_aw[c];
         if (exp_vw.exists(c)) hold_v = exp_vw[c];
         chk("apple_valid", {31'd0, apple_video_valid}, {31'd0, exp_aw.exists(c)});
         chk("vgc_valid", {31'd0, vgc_valid}, {31'd0, exp_vw.exists(c)});
         chk("apple_data", apple_video_data, hold_a);
         chk("vgc_data", vgc_data, hold_v);
         chk("apple_busy", {31'd0, apple_video_busy}, {31'd0, pend[0] || done_c[0] > c});
         chk("vgc_busy", {31'd0, vgc_busy}, {31'd0, pend[1] || done_c[1] > c});
      end
      rst_prev = reset;
      if (reset) begin
         exp_addr.delete();
         exp_aw.delete();
         exp_vw.delete();
         pend[0] = 0; pend[1] = 0;
         done_c[0] = 0; done_c[1] = 0;
         last_g = 1;
         port_free = 0;
         checks_on = 1'b1;
      end else if (checks_on) begin
         if (apple_video_rd && c >= done_c[0]) begin
            pend[0] = 1;
            paddr[0] = {apple_video_bank, apple_video_addr};
            done_c[0] = INF;
         end
         if (vgc_rd && c >= done_c[1]) begin
            pend[1] = 1;
            paddr[1] = {1'b1, 16'(32'h2000 + 4 * int'(vgc_address))};
            done_c[1] = INF;
         end
         if (port_free <= c + 1 && (pend[0] || pend[1])) begin
            int g;
            logic [31:0] word;
            logic [22:0] a;
            if (pend[0] && pend[1]) g = 1 - last_g;
            else g = pend[0] ? 0 : 1;
            last_g = g;
            pend[g] = 0;
            word = '0;
            for (int n = 0; n < 4; n++) begin
               a = {6'h00, paddr[g][16], 16'(paddr[g][15:0] + n)};
               exp_addr[c + 1 + n] = a;
               word[8*n +: 8] = mem_byte(a);
            end
            done_c[g] = c + 5 + L;
            if (g == 0) exp_aw[c + 5 + L] = word;
            else        exp_vw[c + 5 + L] = word;
            port_free = c + 5;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apple_req(input logic [15:0] a, input logic b);
      apple_video_rd = 1'b1; apple_video_addr = a; apple_video_bank = b;
      step(1);
      apple_video_rd = 1'b0;
   endtask

   task automatic vgc_req(input logic [12:0] a);
      vgc_rd = 1'b1; vgc_address = a;
      step(1);
      vgc_rd = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < L; i++) mem_pipe[i] = 8'h00;
      reset = 1'b1;
      apple_video_rd = 1'b0; apple_video_addr = '0; apple_video_bank = 1'b0;
      vgc_rd = 1'b0; vgc_address = '0;
      step(3);
      reset = 1'b0;
      step(2);

      apple_req(16'h0400, 1'b0);
      step(10);
      chk("single_apple_word", apple_video_data, 32'h03020100);

      vgc_req(13'h0000);
      step(10);
      vgc_req(13'h1FFF);
      step(10);
      chk("vgc_last_word", vgc_data, 32'hFFFEFDFC);

      // Simultaneous requests right after reset, then a second tie.
      reset = 1'b1; step(1); reset = 1'b0;
      apple_video_rd = 1'b1; apple_video_addr = 16'h1000; apple_video_bank = 1'b1;
      vgc_rd = 1'b1; vgc_address = 13'h0010;
      step(1);
      apple_video_rd = 1'b0; vgc_rd = 1'b0;
      step(14);
      apple_video_rd = 1'b1; apple_video_addr = 16'h2040; apple_video_bank = 1'b0;
      vgc_rd = 1'b1; vgc_address = 13'h0123;
      step(1);
      apple_video_rd = 1'b0; vgc_rd = 1'b0;
      step(14);

      apple_req(16'hFFFE, 1'b0);
      step(10);
      chk("wrap_word", apple_video_data, 32'h0100FFFE);

      // Ignored second request while busy, then a request in the valid cycle.
      apple_req(16'h0800, 1'b0);
      step(1);
      apple_req(16'h0900, 1'b0);
      step(3);
      apple_req(16'h0A00, 1'b1);
      step(12);

      // Reset in the middle of a fetch, then a fresh request.
      apple_req(16'h0C00, 1'b0);
      step(1);
      reset = 1'b1; step(1); reset = 1'b0;
      step(8);
      apple_req(16'h0D10, 1'b1);
      step(10);

      hash_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         apple_video_rd   = ($urandom % 4) == 0;
         apple_video_addr = 16'($urandom);
         apple_video_bank = 1'($urandom);
         vgc_rd           = ($urandom % 4) == 0;
         vgc_address      = 13'($urandom);
         reset            = ($urandom % 400) == 0;
         step(1);
      end
      apple_video_rd = 1'b0; vgc_rd = 1'b0; reset = 1'b0;
      step(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
